// File: rtl/fft_sched_pkg.sv
// rtl/fft_sched_pkg.sv - shared state encoding and constants for the FFT buffer scheduler
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT = 2**20;
    localparam int ACK_MASK_CYCLES = 2;

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - FFT watchdog counter with load, enable and terminal count
module sched_watchdog
    import fft_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int TMR_W          = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] cnt;

    // Holds at terminal count so an idle watchdog never wraps back through zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/fft_buffer_scheduler.sv
// rtl/fft_buffer_scheduler.sv - ping-pong audio buffer swap and FFT launch sequencer
module fft_buffer_scheduler
    import fft_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int TMR_W          = 21,
    parameter int OVR_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             aud_buff_empty_i,
    output logic             aud_buff_empty_ack_o,
    output logic             aud_buff_filled_o,
    output logic             buff_active_sel_o,
    output logic             fft_start_o,
    input  logic             fft_done_i,
    output logic [OVR_W-1:0] overrun_cnt_o,
    output logic             timeout_o
);

    localparam logic [1:0] MASK_LOAD = 2'(ACK_MASK_CYCLES);

    sched_state_t     state, state_nx;
    logic [1:0]       mask, mask_nx;
    logic             empty_q;
    logic             wd_tc;
    logic             ack_nx, filled_nx, sel_nx, start_nx, timeout_nx;
    logic [OVR_W-1:0] ovr_nx;
    logic             req_ok, overrun_evt;

    sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == SWAP),
        .en    ((state == START) || (state == RUN)),
        .tc    (wd_tc)
    );

    assign req_ok = enable_i && aud_buff_empty_i && (mask == 2'd0);

    // A request landing on the done cycle is serviced next from IDLE, not counted
    assign overrun_evt = (state == RUN) && (mask == 2'd0) && !fft_done_i
                         && aud_buff_empty_i && !empty_q;

    always_comb begin
        state_nx   = state;
        ack_nx     = 1'b0;
        start_nx   = 1'b0;
        filled_nx  = aud_buff_filled_o;
        sel_nx     = buff_active_sel_o;
        timeout_nx = timeout_o;
        mask_nx    = (mask != 2'd0) ? mask - 2'd1 : mask;
        ovr_nx     = overrun_cnt_o;
        if (overrun_evt && (overrun_cnt_o != '1)) begin
            ovr_nx = overrun_cnt_o + 1'b1;
        end

        case (state)
            IDLE: begin
                if (req_ok) begin
                    state_nx  = SWAP;
                    ack_nx    = 1'b1;
                    sel_nx    = ~buff_active_sel_o;
                    filled_nx = 1'b1;
                    mask_nx   = MASK_LOAD;
                end
            end
            SWAP: begin
                state_nx = START;
                start_nx = 1'b1;
            end
            START: begin
                state_nx = RUN;
            end
            RUN: begin
                if (fft_done_i) begin
                    state_nx  = IDLE;
                    filled_nx = 1'b0;
                end else if (wd_tc) begin
                    state_nx   = IDLE;
                    filled_nx  = 1'b0;
                    timeout_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            mask                 <= 2'd0;
            empty_q              <= 1'b0;
            aud_buff_empty_ack_o <= 1'b0;
            aud_buff_filled_o    <= 1'b0;
            buff_active_sel_o    <= 1'b0;
            fft_start_o          <= 1'b0;
            overrun_cnt_o        <= '0;
            timeout_o            <= 1'b0;
        end else begin
            state                <= state_nx;
            mask                 <= mask_nx;
            empty_q              <= aud_buff_empty_i;
            aud_buff_empty_ack_o <= ack_nx;
            aud_buff_filled_o    <= filled_nx;
            buff_active_sel_o    <= sel_nx;
            fft_start_o          <= start_nx;
            overrun_cnt_o        <= ovr_nx;
            timeout_o            <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_fft_buffer_scheduler.sv
// tb/tb_fft_buffer_scheduler.sv - scoreboard bench for the FFT buffer scheduler
module tb_fft_buffer_scheduler;

    localparam int TMO     = 32;
    localparam int OVR_W   = 3;
    localparam int OVR_MAX = (1 << OVR_W) - 1;
    localparam int K_NORM  = 0;
    localparam int K_OVR   = 1;
    localparam int K_GATED = 2;
    localparam int K_TMO   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b1;
    logic             aud_empty = 1'b0;
    logic             fft_done = 1'b0;
    logic             ack, filled, sel, start, timeout;
    logic [OVR_W-1:0] ovr_cnt;

    fft_buffer_scheduler #(
        .TIMEOUT_CYCLES (TMO),
        .TMR_W          (6),
        .OVR_W          (OVR_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable_i             (enable),
        .aud_buff_empty_i     (aud_empty),
        .aud_buff_empty_ack_o (ack),
        .aud_buff_filled_o    (filled),
        .buff_active_sel_o    (sel),
        .fft_start_o          (start),
        .fft_done_i           (fft_done),
        .overrun_cnt_o        (ovr_cnt),
        .timeout_o            (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic sel;
    } exp_t;

    exp_t ack_q[$];
    int   start_q[$];
    int   fall_q[$];
    int   tmo_q[$];

    int   checks = 0;
    int   errors = 0;

    // Reference state of the buffer pair and the FFT engine
    logic sel_m = 1'b0;
    logic tmo_m = 1'b0;
    int   ovr_m = 0;
    int   idle_from = 0;
    bit   pending = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic prev_filled = 1'b0;
    logic prev_tmo = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_filled = 1'b0;
            prev_tmo    = 1'b0;
        end else begin
            if (ack) begin
                if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = ack_q.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_sel", int'(sel), int'(e.sel));
                    chk("ack_filled", int'(filled), 1);
                end
            end
            if (start) begin
                if (start_q.size() == 0) chk("start_unexpected", 1, 0);
                else chk("start_cycle", cyc, start_q.pop_front());
            end
            if (prev_filled && !filled) begin
                if (fall_q.size() == 0) chk("filled_drop_unexpected", 1, 0);
                else chk("filled_drop_cycle", cyc, fall_q.pop_front());
            end
            if (timeout && !prev_tmo) begin
                if (tmo_q.size() == 0) chk("timeout_unexpected", 1, 0);
                else chk("timeout_cycle", cyc, tmo_q.pop_front());
            end
            if (!timeout && prev_tmo) chk("timeout_sticky_lost", 0, 1);
            prev_filled = filled;
            prev_tmo    = timeout;
        end
    end

    // One codec frame: request, swap, FFT pass; expectations derive from the cycle the request is honoured
    task automatic do_frame(input int kind, input int raise_at, input int k, input int dl,
                            input int hold, input int rofs, input bit spur);
        int   q, a, s, d, r, t_end;
        exp_t e;
        if (!pending) begin
            goto(raise_at);
            if (kind == K_GATED) enable = 1'b0;
            aud_empty = 1'b1;
            q = raise_at;
            if (kind == K_GATED) begin
                q = raise_at + hold;
                goto(q);
                enable = 1'b1;
            end
            q = imax(q, idle_from);
        end else begin
            q = idle_from;
        end
        pending = 1'b0;
        a = q + 1;
        s = a + 1;
        sel_m = ~sel_m;
        e.cyc = a;
        e.sel = sel_m;
        ack_q.push_back(e);
        start_q.push_back(s);
        d = (kind == K_TMO) ? -1 : s + k;
        r = (kind == K_OVR) ? s + 2 + rofs : -1;
        t_end = (kind == K_TMO) ? s + TMO : d + 1;
        if (kind == K_TMO) begin
            if (!tmo_m) tmo_q.push_back(t_end);
            tmo_m = 1'b1;
        end
        fall_q.push_back(t_end);
        if (r >= 0 && r < d && ovr_m < OVR_MAX) ovr_m++;
        goto(a);
        while (cyc < t_end) begin
            if (cyc == a + dl) aud_empty = 1'b0;
            if (cyc == r) begin
                aud_empty = 1'b1;
                pending   = 1'b1;
            end
            fft_done = (cyc == d) || (spur && cyc == s);
            @(posedge clk);
            #1;
        end
        fft_done = 1'b0;
        idle_from = t_end;
        chk("overrun_cnt", int'(ovr_cnt), ovr_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int q, a, s;
        exp_t e;
        goto(2);
        chk("rst_ack", int'(ack), 0);
        chk("rst_filled", int'(filled), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_ovr", int'(ovr_cnt), 0);
        chk("rst_timeout", int'(timeout), 0);
        goto(3);
        rst_n = 1'b1;
        idle_from = 3;

        do_frame(K_NORM, 10, 28, 1, 0, 0, 1'b0);
        do_frame(K_NORM, cyc + 2, 20, 1, 0, 0, 1'b0);
        do_frame(K_NORM, cyc + 2, 20, 2, 0, 0, 1'b0);
        do_frame(K_OVR, cyc + 1, 30, 2, 0, 5, 1'b0);
        do_frame(K_NORM, cyc, 10, 1, 0, 0, 1'b0);
        do_frame(K_GATED, cyc + 3, 12, 1, 50, 0, 1'b0);
        do_frame(K_TMO, cyc + 1, 0, 1, 0, 0, 1'b0);
        do_frame(K_NORM, cyc + 1, TMO - 1, 1, 0, 0, 1'b0);
        do_frame(K_NORM, cyc, 1, 1, 0, 0, 1'b1);
        do_frame(K_OVR, cyc + 2, 10, 2, 0, 8, 1'b0);
        do_frame(K_NORM, cyc, 5, 1, 0, 0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            int kind, k, sel_k;
            sel_k = $urandom_range(0, 9);
            kind = (sel_k < 4) ? K_NORM : (sel_k < 7) ? K_OVR : (sel_k < 8) ? K_GATED : K_TMO;
            k = (kind == K_OVR) ? $urandom_range(2, TMO - 1) : $urandom_range(1, TMO - 1);
            do_frame(kind, imax(cyc, idle_from) + $urandom_range(0, 4), k,
                     $urandom_range(1, 2), $urandom_range(1, 20),
                     (k >= 2) ? $urandom_range(0, k - 2) : 0, $urandom_range(0, 3) == 0);
        end
        if (pending) do_frame(K_NORM, cyc, 3, 1, 0, 0, 1'b0);
        chk("timeout_held", int'(timeout), int'(tmo_m));

        // Reset in the middle of an FFT pass must clear everything without waiting for a clock
        goto(imax(cyc, idle_from));
        aud_empty = 1'b1;
        q = cyc;
        a = q + 1;
        s = a + 1;
        sel_m = ~sel_m;
        e.cyc = a;
        e.sel = sel_m;
        ack_q.push_back(e);
        start_q.push_back(s);
        goto(a + 1);
        aud_empty = 1'b0;
        goto(s + 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ack", int'(ack), 0);
        chk("async_rst_filled", int'(filled), 0);
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_start", int'(start), 0);
        chk("async_rst_ovr", int'(ovr_cnt), 0);
        chk("async_rst_timeout", int'(timeout), 0);
        goto(cyc + 2);
        rst_n = 1'b1;
        sel_m = 1'b0;
        tmo_m = 1'b0;
        ovr_m = 0;
        goto(cyc + 1);
        fft_done = 1'b1;
        goto(cyc + 1);
        fft_done = 1'b0;
        goto(cyc + 3);
        chk("late_done_filled", int'(filled), 0);
        idle_from = cyc;
        do_frame(K_NORM, cyc + 1, 6, 1, 0, 0, 1'b0);

        goto(cyc + 5);
        chk("ack_q_left", ack_q.size(), 0);
        chk("start_q_left", start_q.size(), 0);
        chk("fall_q_left", fall_q.size(), 0);
        chk("tmo_q_left", tmo_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
